// File: rtl/rgb2luma_pipe.sv
// Three-stage RGB-to-luma pipeline: multiply, sum, then round and saturate.
// Define RGB2LUMA_THRESH_EN to add iTHRESH/oBIN dark-pixel flagging.
module rgb2luma_pipe #(
  parameter int DW      = 10,
  parameter int CW      = 8,
  parameter int KR_INIT = 77,
  parameter int KG_INIT = 150,
  parameter int KB_INIT = 29
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iDVAL,
  output logic          oREADY,
  input  logic [DW-1:0] iRed,
  input  logic [DW-1:0] iGreen,
  input  logic [DW-1:0] iBlue,
  input  logic          iSOF,
  input  logic          iEOL,
  input  logic          iCOEF_WE,
  input  logic [CW-1:0] iKR,
  input  logic [CW-1:0] iKG,
  input  logic [CW-1:0] iKB,
  output logic          oDVAL,
  input  logic          iREADY,
  output logic [DW-1:0] oDATA,
  output logic          oSOF,
`ifdef RGB2LUMA_THRESH_EN
  input  logic [DW-1:0] iTHRESH,
  output logic          oBIN,
`endif
  output logic          oEOL
);

  localparam int PW = DW + CW;
  localparam int SW = DW + CW + 2;
  localparam int RW = SW + 1;
  localparam int YW = RW - CW;
  localparam logic [RW-1:0] RND =
    {{(RW-CW){1'b0}}, 1'b1, {(CW-1){1'b0}}};

  logic          en;
  logic          acc;

  logic [CW-1:0] kr_q, kr_d;
  logic [CW-1:0] kg_q, kg_d;
  logic [CW-1:0] kb_q, kb_d;

  logic          s1_vld_q, s1_vld_d;
  logic [PW-1:0] s1_pr_q, s1_pr_d;
  logic [PW-1:0] s1_pg_q, s1_pg_d;
  logic [PW-1:0] s1_pb_q, s1_pb_d;
  logic          s1_sof_q, s1_sof_d;
  logic          s1_eol_q, s1_eol_d;

  logic          s2_vld_q, s2_vld_d;
  logic [SW-1:0] s2_sum_q, s2_sum_d;
  logic          s2_sof_q, s2_sof_d;
  logic          s2_eol_q, s2_eol_d;

  logic          s3_vld_q, s3_vld_d;
  logic [DW-1:0] s3_y_q, s3_y_d;
  logic          s3_sof_q, s3_sof_d;
  logic          s3_eol_q, s3_eol_d;
`ifdef RGB2LUMA_THRESH_EN
  logic          s3_bin_q, s3_bin_d;
`endif

  logic [RW-1:0] rnd;
  logic [YW-1:0] yfull;
  logic [DW-1:0] ysat;

  always_comb begin
    en  = !s3_vld_q || iREADY;
    acc = iDVAL && en;

    kr_d = kr_q;
    kg_d = kg_q;
    kb_d = kb_q;
    if (iCOEF_WE) begin
      kr_d = iKR;
      kg_d = iKG;
      kb_d = iKB;
    end

    rnd   = {1'b0, s2_sum_q} + RND;
    yfull = YW'(rnd >> CW);
    if (|yfull[YW-1:DW]) ysat = '1;
    else                 ysat = yfull[DW-1:0];

    s1_vld_d = s1_vld_q;
    s1_pr_d  = s1_pr_q;
    s1_pg_d  = s1_pg_q;
    s1_pb_d  = s1_pb_q;
    s1_sof_d = s1_sof_q;
    s1_eol_d = s1_eol_q;
    s2_vld_d = s2_vld_q;
    s2_sum_d = s2_sum_q;
    s2_sof_d = s2_sof_q;
    s2_eol_d = s2_eol_q;
    s3_vld_d = s3_vld_q;
    s3_y_d   = s3_y_q;
    s3_sof_d = s3_sof_q;
    s3_eol_d = s3_eol_q;
`ifdef RGB2LUMA_THRESH_EN
    s3_bin_d = s3_bin_q;
`endif

    // Old coefficients apply to a pixel accepted alongside a write.
    if (en) begin
      s1_vld_d = acc;
      s1_pr_d  = PW'(iRed)   * PW'(kr_q);
      s1_pg_d  = PW'(iGreen) * PW'(kg_q);
      s1_pb_d  = PW'(iBlue)  * PW'(kb_q);
      s1_sof_d = iSOF && acc;
      s1_eol_d = iEOL && acc;

      s2_vld_d = s1_vld_q;
      s2_sum_d = SW'(s1_pr_q) + SW'(s1_pg_q)
               + SW'(s1_pb_q);
      s2_sof_d = s1_sof_q;
      s2_eol_d = s1_eol_q;

      s3_vld_d = s2_vld_q;
      s3_y_d   = ysat;
      s3_sof_d = s2_sof_q;
      s3_eol_d = s2_eol_q;
`ifdef RGB2LUMA_THRESH_EN
      s3_bin_d = ysat < iTHRESH;
`endif
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      kr_q     <= CW'(KR_INIT);
      kg_q     <= CW'(KG_INIT);
      kb_q     <= CW'(KB_INIT);
      s1_vld_q <= 1'b0;
      s1_pr_q  <= '0;
      s1_pg_q  <= '0;
      s1_pb_q  <= '0;
      s1_sof_q <= 1'b0;
      s1_eol_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s2_sum_q <= '0;
      s2_sof_q <= 1'b0;
      s2_eol_q <= 1'b0;
      s3_vld_q <= 1'b0;
      s3_y_q   <= '0;
      s3_sof_q <= 1'b0;
      s3_eol_q <= 1'b0;
`ifdef RGB2LUMA_THRESH_EN
      s3_bin_q <= 1'b0;
`endif
    end else begin
      kr_q     <= kr_d;
      kg_q     <= kg_d;
      kb_q     <= kb_d;
      s1_vld_q <= s1_vld_d;
      s1_pr_q  <= s1_pr_d;
      s1_pg_q  <= s1_pg_d;
      s1_pb_q  <= s1_pb_d;
      s1_sof_q <= s1_sof_d;
      s1_eol_q <= s1_eol_d;
      s2_vld_q <= s2_vld_d;
      s2_sum_q <= s2_sum_d;
      s2_sof_q <= s2_sof_d;
      s2_eol_q <= s2_eol_d;
      s3_vld_q <= s3_vld_d;
      s3_y_q   <= s3_y_d;
      s3_sof_q <= s3_sof_d;
      s3_eol_q <= s3_eol_d;
`ifdef RGB2LUMA_THRESH_EN
      s3_bin_q <= s3_bin_d;
`endif
    end
  end

  assign oREADY = en;
  assign oDVAL  = s3_vld_q;
  assign oDATA  = s3_y_q;
  assign oSOF   = s3_sof_q;
  assign oEOL   = s3_eol_q;
`ifdef RGB2LUMA_THRESH_EN
  assign oBIN   = s3_bin_q;
`endif

endmodule

// File: tb/tb_rgb2luma_pipe.sv
// Bench for rgb2luma_pipe: random and directed pixels against
// an arithmetic luma model with a scoreboard queue.
module tb_rgb2luma_pipe;

  localparam int DW = 10;
  localparam int CW = 8;

  logic          iCLK = 1'b0;
  logic          iRST = 1'b0;
  logic          iDVAL = 1'b0;
  logic          oREADY;
  logic [DW-1:0] iRed = '0;
  logic [DW-1:0] iGreen = '0;
  logic [DW-1:0] iBlue = '0;
  logic          iSOF = 1'b0;
  logic          iEOL = 1'b0;
  logic          iCOEF_WE = 1'b0;
  logic [CW-1:0] iKR = '0;
  logic [CW-1:0] iKG = '0;
  logic [CW-1:0] iKB = '0;
  logic          oDVAL;
  logic          iREADY = 1'b1;
  logic [DW-1:0] oDATA;
  logic          oSOF;
  logic          oEOL;
`ifdef RGB2LUMA_THRESH_EN
  logic [DW-1:0] iTHRESH = 10'd512;
  logic          oBIN;
`endif

  rgb2luma_pipe dut (
    .iCLK(iCLK), .iRST(iRST),
    .iDVAL(iDVAL), .oREADY(oREADY),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .iSOF(iSOF), .iEOL(iEOL),
    .iCOEF_WE(iCOEF_WE),
    .iKR(iKR), .iKG(iKG), .iKB(iKB),
    .oDVAL(oDVAL), .iREADY(iREADY),
    .oDATA(oDATA), .oSOF(oSOF),
`ifdef RGB2LUMA_THRESH_EN
    .iTHRESH(iTHRESH), .oBIN(oBIN),
`endif
    .oEOL(oEOL)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [DW-1:0] y;
    logic          sof;
    logic          eol;
    logic          bin;
    int            cyc;
  } pix_t;

  pix_t exp_q[$];
  pix_t got_q[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int m_kr   = 77;
  int m_kg   = 150;
  int m_kb   = 29;

  logic          obs_acc;
  logic          obs_dval;
  logic          obs_rdy;
  logic [DW-1:0] obs_data;

  function automatic int luma(int r, int g, int b,
                              int kr, int kg, int kb);
    int y;
    y = (r * kr + g * kg + b * kb + 128) / 256;
    if (y > 1023) y = 1023;
    return y;
  endfunction

  task automatic step(input logic dv, input int r, input int g,
                      input int b, input logic sof, input logic eol,
                      input logic we, input int kr, input int kg,
                      input int kb, input logic rdy);
    pix_t e;
    pix_t o;
    @(negedge iCLK);
    iDVAL    = dv;
    iRed     = r[DW-1:0];
    iGreen   = g[DW-1:0];
    iBlue    = b[DW-1:0];
    iSOF     = sof;
    iEOL     = eol;
    iCOEF_WE = we;
    iKR      = kr[CW-1:0];
    iKG      = kg[CW-1:0];
    iKB      = kb[CW-1:0];
    iREADY   = rdy;
    #1;
    obs_acc  = iDVAL && oREADY;
    obs_dval = oDVAL;
    obs_rdy  = oREADY;
    obs_data = oDATA;
    if (obs_acc) begin
      e.y   = DW'(luma(r, g, b, m_kr, m_kg, m_kb));
      e.sof = sof;
      e.eol = eol;
`ifdef RGB2LUMA_THRESH_EN
      e.bin = e.y < 10'd512;
`else
      e.bin = 1'b0;
`endif
      e.cyc = cyc;
      exp_q.push_back(e);
    end
    if (we) begin
      m_kr = kr; m_kg = kg; m_kb = kb;
    end
    if (oDVAL && iREADY) begin
      o.y   = oDATA;
      o.sof = oSOF;
      o.eol = oEOL;
`ifdef RGB2LUMA_THRESH_EN
      o.bin = oBIN;
`else
      o.bin = 1'b0;
`endif
      o.cyc = cyc;
      got_q.push_back(o);
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic pix(input int r, input int g, input int b);
    step(1, r, g, b, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && got_q.size() < exp_q.size(); i++)
      idle(1);
    idle(4);
  endtask

  task automatic test_reset();
    #2;
    n_chk++;
    if (oDVAL !== 1'b0 || oDATA !== '0 || oSOF !== 1'b0
        || oEOL !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got dval=%b data=%0d sof=%b eol=%b need 0",
               oDVAL, oDATA, oSOF, oEOL);
    end
    @(negedge iCLK);
    iRST = 1'b1;
    idle(3);
    n_chk++;
    if (got_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_idle: got %0d outputs need 0", got_q.size());
    end
  endtask

  task automatic test_basic();
    int need[4] = '{1023, 308, 0, 512};
    exp_q.delete(); got_q.delete();
    pix(1023, 1023, 1023);
    pix(1023, 0, 0);
    pix(0, 0, 0);
    pix(512, 512, 512);
    drain();
    n_chk++;
    if (got_q.size() != 4) begin
      n_fail++;
      $display("FAIL basic_count: got %0d need 4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (got_q[i].y !== DW'(need[i])) begin
          n_fail++;
          $display("FAIL basic_y%0d: got %0d need %0d",
                   i, got_q[i].y, need[i]);
        end
      end
    end
`ifdef RGB2LUMA_THRESH_EN
    if (got_q.size() == 4) begin
      n_chk++;
      if (got_q[1].bin !== 1'b1) begin
        n_fail++;
        $display("FAIL thresh_dark: got %b need 1", got_q[1].bin);
      end
    end
    exp_q.delete(); got_q.delete();
    pix(600, 600, 600);
    drain();
    n_chk++;
    if (got_q.size() != 1 || got_q[0].bin !== 1'b0) begin
      n_fail++;
      $display("FAIL thresh_bright: got n=%0d need n=1 bin=0",
               got_q.size());
    end
`endif
  endtask

  task automatic test_latency();
    exp_q.delete(); got_q.delete();
    pix(1023, 1023, 1023);
    drain();
    n_chk++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++;
      $display("FAIL latency_count: got %0d need 1", got_q.size());
    end else begin
      n_chk++;
      if (got_q[0].cyc - exp_q[0].cyc != 3) begin
        n_fail++;
        $display("FAIL latency: got %0d need 3",
                 got_q[0].cyc - exp_q[0].cyc);
      end
      n_chk++;
      if (got_q[0].y !== 10'd1023) begin
        n_fail++;
        $display("FAIL latency_y: got %0d need 1023", got_q[0].y);
      end
    end
  endtask

  task automatic test_coef();
    int need[4] = '{308, 1019, 1023, 1023};
    exp_q.delete(); got_q.delete();
    step(1, 1023, 0, 0, 0, 0, 1, 255, 255, 255, 1);
    pix(1023, 0, 0);
    pix(1023, 1023, 1023);
    pix(400, 400, 400);
    drain();
    n_chk++;
    if (got_q.size() != 4) begin
      n_fail++;
      $display("FAIL coef_count: got %0d need 4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (got_q[i].y !== DW'(need[i])) begin
          n_fail++;
          $display("FAIL coef_y%0d: got %0d need %0d",
                   i, got_q[i].y, need[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    exp_q.delete(); got_q.delete();
    pix(100, 200, 300);
    pix(500, 500, 500);
    pix(900, 10, 20);
    @(negedge iCLK);
    iDVAL = 1'b0;
    iRST  = 1'b0;
    #1;
    n_chk++;
    if (oDVAL !== 1'b0 || oDATA !== '0) begin
      n_fail++;
      $display("FAIL midreset_out: got dval=%b data=%0d need 0 0",
               oDVAL, oDATA);
    end
    @(negedge iCLK);
    iRST = 1'b1;
    exp_q.delete();
    m_kr = 77; m_kg = 150; m_kb = 29;
    idle(6);
    n_chk++;
    if (got_q.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_flush: got %0d outputs need 0",
               got_q.size());
    end
    pix(1023, 0, 0);
    drain();
    n_chk++;
    if (got_q.size() != 1 || got_q[0].y !== 10'd308) begin
      n_fail++;
      $display("FAIL midreset_coef: got n=%0d need n=1 y=308",
               got_q.size());
    end
  endtask

  task automatic test_stall();
    int            idx = 0;
    int            r, g, b;
    logic          rdy;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    int            stalls = 0;
    exp_q.delete(); got_q.delete();
    r = $urandom_range(1023); g = $urandom_range(1023);
    b = $urandom_range(1023);
    for (int k = 0; k < 100 && idx < 8; k++) begin
      rdy = !(k >= 3 && k < 8);
      step(1, r, g, b, idx == 0, idx == 7, 0, 0, 0, 0, rdy);
      if (obs_dval && !rdy) begin
        stalls++;
        n_chk++;
        if (obs_rdy !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_oready: got %b need 0", obs_rdy);
        end
      end
      if (prev_stall) begin
        n_chk++;
        if (obs_data !== prev_data) begin
          n_fail++;
          $display("FAIL stall_hold: got %0d need %0d",
                   obs_data, prev_data);
        end
      end
      prev_stall = obs_dval && !rdy;
      prev_data  = obs_data;
      if (obs_acc) begin
        idx++;
        r = $urandom_range(1023); g = $urandom_range(1023);
        b = $urandom_range(1023);
      end
    end
    drain();
    n_chk++;
    if (stalls != 5 || got_q.size() != 8 || exp_q.size() != 8) begin
      n_fail++;
      $display("FAIL stall_count: got stalls=%0d out=%0d need 5 8",
               stalls, got_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_chk++;
        if (got_q[i].y !== exp_q[i].y || got_q[i].sof !== exp_q[i].sof
            || got_q[i].eol !== exp_q[i].eol) begin
          n_fail++;
          $display("FAIL stall_pix%0d: got y=%0d s=%b e=%b need y=%0d s=%b e=%b",
                   i, got_q[i].y, got_q[i].sof, got_q[i].eol,
                   exp_q[i].y, exp_q[i].sof, exp_q[i].eol);
        end
      end
    end
  endtask

  task automatic test_random();
    exp_q.delete(); got_q.delete();
    for (int k = 0; k < 120; k++)
      step($urandom_range(3) != 0,
           $urandom_range(1023), $urandom_range(1023),
           $urandom_range(1023),
           $urandom_range(1), $urandom_range(1),
           $urandom_range(9) == 0,
           $urandom_range(255), $urandom_range(255),
           $urandom_range(255),
           $urandom_range(3) != 0);
    drain();
    n_chk++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL random_count: got %0d need %0d",
               got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < got_q.size(); i++) begin
        n_chk++;
        if (got_q[i].y !== exp_q[i].y || got_q[i].sof !== exp_q[i].sof
            || got_q[i].eol !== exp_q[i].eol
            || got_q[i].bin !== exp_q[i].bin) begin
          n_fail++;
          $display("FAIL random_pix%0d: got y=%0d s=%b e=%b need y=%0d s=%b e=%b",
                   i, got_q[i].y, got_q[i].sof, got_q[i].eol,
                   exp_q[i].y, exp_q[i].sof, exp_q[i].eol);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_coef();
    test_reset_midstream();
    test_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
